alu_exec: RTL and testbench
===========================

Name: alu_exec

Overview:
- Execute stage directly downstream of the register file in the RV32I non-pipelined core.
- Consumes the two read operands (RD1→op_a; RD2 or immediate→op_b) plus a decoded ALU opcode.
- Produces a registered result for writeback and a zero flag for branch resolution.
- Shifts are iterative, 1 bit/cycle; all other ops take 1 cycle. Valid/ready handshake on both sides.

Parameters:
- XLEN, 32, datapath width (fixed at 32 for RV32I; shift amount is always op_b[4:0]).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands/opcode valid.
- in_ready  out  1  block can accept an op.
- alu_op  in  4  opcode. 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND; 10–15 reserved.
- op_a  in  XLEN  first operand (RD1).
- op_b  in  XLEN  second operand (RD2 or immediate).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  XLEN  registered result.
- zero  out  1  result == 0, registered alongside result.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; out_valid=0; result=0; zero=0; shift counter=0; captured operands=0.
  - Effect is immediate and aborts any in-flight op without producing a result.
- Handshakes:
  - in_ready = (state==IDLE), purely from state.
  - Accept occurs on in_valid && in_ready at a rising edge. op_a, op_b[4:0] and alu_op are captured; later input changes are ignored.
  - Output transfer occurs on out_valid && out_ready.
- States:
  - IDLE: waits for an accept.
    - Non-shift op: compute and register result/zero; go to DONE. out_valid=1 the cycle after accept (latency 1).
    - Shift op with shamt==0: result=op_a; go to DONE (latency 1).
    - Shift op with shamt>0: load the working register with op_a and the counter with shamt; go to SHIFT.
  - SHIFT: each cycle shifts the working register 1 bit and decrements the counter.
    - SLL fills with 0. SRL fills with 0. SRA fills with bit 31.
    - When the counter reaches 0, go to DONE. Total accept-to-out_valid latency = shamt+1 cycles (max 32).
  - DONE: out_valid=1; result and zero held stable.
    - out_ready=1 → IDLE; out_valid drops the next cycle.
    - in_ready=0 throughout DONE, so no same-cycle accept. Peak throughput is one op per 2 cycles.
- Arithmetic (all modulo 2^32):
  - ADD/SUB wrap with no overflow flag.
  - SLT is a signed compare; SLTU is unsigned. Both give result={31'b0, lt}.
  - Reserved opcodes: result=0, zero=1, latency 1, no error.
- zero is computed from the final result value in every path.
- Backpressure: out_ready may stay low indefinitely; result is held, no op is dropped, no new op is accepted.
- Reset mid-SHIFT or mid-DONE returns to IDLE with out_valid=0; the pending result is discarded.

Optional Feature:
- Macro: ALU_EXEC_FAST_SHIFT_EN.
  - Defined: shifts use a single-cycle barrel shifter. SHIFT state and counter are removed; every op has latency 1.
  - Undefined: iterative shifter as described above, for minimum area.
- Interface and all other behaviour are identical in both builds.

Decomposition:
- Shared package alu_pkg holds:
  - alu_op encodings: ALU_ADD..ALU_AND as 4-bit localparams, shared with the decoder.
  - State encodings: ST_IDLE, ST_SHIFT, ST_DONE.
  - XLEN and SHAMT_W=5.
- One natural sub-module, alu_shifter:
  - Iterative shift engine (load/step/done), or a barrel shifter under ALU_EXEC_FAST_SHIFT_EN.
- Compare/logic/add stay inline in alu_exec.

Test Plan:
- ADD: op_a=5, op_b=6, out_ready=1 → out_valid 1 cycle after accept, result=0x0000000B, zero=0.
- SUB: op_a=2, op_b=2 → result=0, zero=1; then SUB 0-1 → result=0xFFFFFFFF (wrap).
- Compare: op_a=0xFFFFFFFF, op_b=1. SLT → result=1. SLTU → result=0.
- SRA: op_a=0x80000000, op_b=4 → out_valid exactly 5 cycles after accept (1 in fast build), result=0xF8000000.
  - SLL of 1 by 31 → 0x80000000 after 32 cycles.
  - SRL by 0 → op_a unchanged, latency 1.
- Backpressure: after AND 0xF0F0F0F0 & 0x0FF00FF0 (expected 0x00F000F0), hold out_ready=0 for 3 cycles with in_valid=1 → result stable, in_ready=0, nothing accepted. Then out_ready=1 → IDLE next cycle, queued op accepted.
- Reset: assert rst_n=0 mid-shift (SLL by 20 at cycle 7) → out_valid=0, result=0, busy=0 immediately. After release, ADD 1+1 → result=2 with normal latency.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the RV32I execute stage: ALU opcodes, FSM states and widths.
// Used by alu_exec and alu_shifter (shift engine selected by ALU_EXEC_FAST_SHIFT_EN).
package alu_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// Shift engine for alu_exec: 1 bit/cycle iterative shifter by default, or a
// single-cycle barrel shifter when ALU_EXEC_FAST_SHIFT_EN is defined.
module alu_shifter
    import alu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [3:0]          op,
    input  logic [XLEN-1:0]     data_in,
    input  logic [SHAMT_W-1:0]  shamt_in,
    output logic [XLEN-1:0]     imm_out,
    output logic [XLEN-1:0]     step_out,
    output logic                last
);

`ifdef ALU_EXEC_FAST_SHIFT_EN

    logic [XLEN-1:0] barrel_s;
    logic            unused_s;

    assign unused_s = &{1'b0, clk, rst_n, load};

    // Full shift of the live operand in one cycle
    always_comb begin
        barrel_s = data_in;
        case (op)
            ALU_SLL: barrel_s = data_in << shamt_in;
            ALU_SRL: barrel_s = data_in >> shamt_in;
            ALU_SRA: barrel_s = $unsigned($signed(data_in) >>> shamt_in);
            default: barrel_s = data_in;
        endcase
    end

    assign imm_out  = barrel_s;
    assign step_out = barrel_s;
    assign last     = 1'b1;

`else

    logic [XLEN-1:0]    work_r;
    logic [SHAMT_W-1:0] cnt_r;
    logic [3:0]         op_r;
    logic [XLEN-1:0]    step_s;

    // One-bit shift of the working register; fill depends on captured opcode
    always_comb begin
        step_s = work_r;
        case (op_r)
            ALU_SLL: step_s = {work_r[XLEN-2:0], 1'b0};
            ALU_SRL: step_s = {1'b0, work_r[XLEN-1:1]};
            ALU_SRA: step_s = {work_r[XLEN-1], work_r[XLEN-1:1]};
            default: step_s = work_r;
        endcase
    end

    // Working register and remaining-shift counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_r <= {XLEN{1'b0}};
            cnt_r  <= {SHAMT_W{1'b0}};
            op_r   <= 4'd0;
        end else if (load) begin
            work_r <= data_in;
            cnt_r  <= shamt_in;
            op_r   <= op;
        end else if (cnt_r != {SHAMT_W{1'b0}}) begin
            work_r <= step_s;
            cnt_r  <= cnt_r - 5'd1;
        end
    end

    // shamt==0 needs no shifting, so the immediate path is the operand itself
    assign imm_out  = data_in;
    assign step_out = step_s;
    assign last     = (cnt_r == 5'd1);

`endif

endmodule

// File: rtl/alu_exec.sv
// RV32I execute stage: registered ALU result and zero flag with valid/ready on both sides.
// Define ALU_EXEC_FAST_SHIFT_EN for single-cycle shifts; default build shifts 1 bit/cycle.
module alu_exec
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [XLEN-1:0]  op_a,
    input  logic [XLEN-1:0]  op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic             zero,
    output logic             busy
);

    logic [1:0]      state_r;
    logic            out_valid_r;
    logic [XLEN-1:0] result_r;
    logic            zero_r;

    logic            go_shift_s;
    logic            shift_load_s;
    logic [XLEN-1:0] shift_imm_s;
    logic [XLEN-1:0] shift_step_s;
    logic            shift_last_s;
    logic [XLEN-1:0] alu_calc_s;
    logic            lt_s;
    logic            ltu_s;

`ifdef ALU_EXEC_FAST_SHIFT_EN
    assign go_shift_s = 1'b0;
`else
    assign go_shift_s = is_shift(alu_op) && (op_b[SHAMT_W-1:0] != 5'd0);
`endif

    assign in_ready     = (state_r == ST_IDLE);
    assign busy         = (state_r != ST_IDLE);
    assign shift_load_s = in_valid && in_ready && go_shift_s;
    assign lt_s         = $signed(op_a) < $signed(op_b);
    assign ltu_s        = op_a < op_b;

    alu_shifter u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (shift_load_s),
        .op       (alu_op),
        .data_in  (op_a),
        .shamt_in (op_b[SHAMT_W-1:0]),
        .imm_out  (shift_imm_s),
        .step_out (shift_step_s),
        .last     (shift_last_s)
    );

    // Single-cycle result for every op that completes at accept time
    always_comb begin
        alu_calc_s = {XLEN{1'b0}};
        case (alu_op)
            ALU_ADD:                   alu_calc_s = op_a + op_b;
            ALU_SUB:                   alu_calc_s = op_a - op_b;
            ALU_SLL, ALU_SRL, ALU_SRA: alu_calc_s = shift_imm_s;
            ALU_SLT:                   alu_calc_s = {{(XLEN-1){1'b0}}, lt_s};
            ALU_SLTU:                  alu_calc_s = {{(XLEN-1){1'b0}}, ltu_s};
            ALU_XOR:                   alu_calc_s = op_a ^ op_b;
            ALU_OR:                    alu_calc_s = op_a | op_b;
            ALU_AND:                   alu_calc_s = op_a & op_b;
            default:                   alu_calc_s = {XLEN{1'b0}};
        endcase
    end

    // Control FSM and registered result/zero/out_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            result_r    <= {XLEN{1'b0}};
            zero_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (go_shift_s) begin
                            state_r <= ST_SHIFT;
                        end else begin
                            result_r    <= alu_calc_s;
                            zero_r      <= (alu_calc_s == {XLEN{1'b0}});
                            out_valid_r <= 1'b1;
                            state_r     <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    // Final step is taken straight into result, saving a cycle
                    if (shift_last_s) begin
                        result_r    <= shift_step_s;
                        zero_r      <= (shift_step_s == {XLEN{1'b0}});
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign zero      = zero_r;

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed cases plus randomized ops against a reference model.
// Follows ALU_EXEC_FAST_SHIFT_EN to select expected shift latency.
module tb_alu_exec;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

`ifdef ALU_EXEC_FAST_SHIFT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    alu_exec dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        longint sa;
        longint sb;
        sh = int'(b % 32);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a * (32'd1 << sh);
            4'd3: return (sa < sb) ? 32'd1 : 32'd0;
            4'd4: return (a < b) ? 32'd1 : 32'd0;
            4'd5: return a ^ b;
            4'd6: return a / (32'd1 << sh);
            4'd7: begin
                // floor division by 2^sh gives arithmetic right shift
                if (sa < 0) return 32'((sa - ((64'sd1 << sh) - 1)) / (64'sd1 << sh));
                else        return 32'(sa / (64'sd1 << sh));
            end
            4'd8: return a | b;
            4'd9: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [3:0] op, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        if (!FAST && (op == 4'd2 || op == 4'd6 || op == 4'd7) && sh != 0) return sh + 1;
        return 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt = total_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else begin
            fail_cnt = fail_cnt + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op, measure latency, optionally stall, then drain the result
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        logic [31:0] exp_r;
        int          exp_lat;
        int          lat;
        exp_r   = ref_result(op, a, b);
        exp_lat = ref_latency(op, b);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        out_ready = 1'b0;
        alu_op    = op;
        op_a      = a;
        op_b      = b;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        alu_op   = 4'($urandom);
        op_a     = $urandom;
        op_b     = $urandom;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_result"}, result, exp_r);
        check({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_r == 32'd0});
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check({tag, "_hold_result"}, result, exp_r);
            check({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_drained"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        alu_op    = 4'd0;
        op_a      = 32'd0;
        op_b      = 32'd0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("add", 4'd0, 32'd5, 32'd6, 0);
        check("add_value", result, 32'h0000000B);
        run_op("sub_eq", 4'd1, 32'd2, 32'd2, 0);
        run_op("sub_wrap", 4'd1, 32'd0, 32'd1, 0);
        check("sub_wrap_value", result, 32'hFFFFFFFF);
        run_op("slt", 4'd3, 32'hFFFFFFFF, 32'd1, 0);
        check("slt_value", result, 32'd1);
        run_op("sltu", 4'd4, 32'hFFFFFFFF, 32'd1, 0);
        check("sltu_value", result, 32'd0);
        run_op("sra4", 4'd7, 32'h80000000, 32'd4, 0);
        check("sra4_value", result, 32'hF8000000);
        run_op("sll31", 4'd2, 32'd1, 32'd31, 0);
        check("sll31_value", result, 32'h80000000);
        run_op("srl0", 4'd6, 32'h12345678, 32'h00000020, 0);
        check("srl0_value", result, 32'h12345678);
        run_op("rsvd", 4'd12, 32'h1234, 32'h5678, 1);

        // Backpressure with a queued op waiting on in_valid
        out_ready = 1'b0;
        alu_op    = 4'd9;
        op_a      = 32'hF0F0F0F0;
        op_b      = 32'h0FF00FF0;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        alu_op = 4'd0;
        op_a   = 32'd3;
        op_b   = 32'd4;
        check("bp_and", result, 32'h00F000F0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("bp_hold_result", result, 32'h00F000F0);
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", {31'd0, out_valid}, 32'd0);
        check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_queued_valid", {31'd0, out_valid}, 32'd1);
        check("bp_queued_result", result, 32'd7);
        @(posedge clk); #1;
        check("bp_queued_drained", {31'd0, out_valid}, 32'd0);

        // Reset in the middle of a long shift
        out_ready = 1'b1;
        alu_op    = 4'd2;
        op_a      = 32'd1;
        op_b      = 32'd20;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("rstmid_busy_before", {31'd0, busy}, FAST ? 32'd0 : 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstmid_out_valid", {31'd0, out_valid}, 32'd0);
        check("rstmid_result", result, 32'd0);
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rstmid_idle", {31'd0, out_valid}, 32'd0);
        run_op("post_rst_add", 4'd0, 32'd1, 32'd1, 0);
        check("post_rst_value", result, 32'd2);

        for (int i = 0; i < 40; i++) begin
            logic [3:0]  r_op;
            logic [31:0] r_a;
            logic [31:0] r_b;
            r_op = 4'($urandom_range(0, 15));
            r_a  = $urandom;
            r_b  = $urandom;
            if (i % 4 == 0) r_b = r_a;
            run_op($sformatf("rnd%0d", i), r_op, r_a, r_b, int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
